// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates I-miss, D-miss and D-store requests onto one
// pipelined memory port and streams line-fill words back into the owning cache.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_miss, i_addr                I-cache fill request and miss address
//   d_miss, d_wr, d_addr, d_wdata D-cache fill / store request
//   mem_rdata, mem_rvalid         memory read return (in issue order)
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                     memory access issue
//   i_fill_we, d_fill_we,
//   fill_word, fill_data          fill strobes into the cache data arrays
//   i_done, d_done                one-cycle completion pulses
//   busy                          high while not idle
module cache_fill_ctrl #(
    parameter int WORDS_PER_LINE = 8,
    localparam int WW = $clog2(WORDS_PER_LINE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_miss,
    input  logic [15:0]   i_addr,
    input  logic          d_miss,
    input  logic          d_wr,
    input  logic [15:0]   d_addr,
    input  logic [15:0]   d_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rvalid,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          i_fill_we,
    output logic          d_fill_we,
    output logic [WW-1:0] fill_word,
    output logic [15:0]   fill_data,
    output logic          i_done,
    output logic          d_done,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        DONE
    } state_t;

    localparam logic [15:0] LINE_MASK =
        ~(16'(2 * WORDS_PER_LINE) - 16'd1);
    localparam logic [WW:0]   ISSUE_END = (WW + 1)'(WORDS_PER_LINE);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);

    state_t        state;
    logic          owner_i;
    logic [15:0]   base;
    logic [15:0]   wdata;
    // One extra bit so the issue counter can sit at WORDS_PER_LINE when done.
    logic [WW:0]   issue_cnt;
    logic [WW-1:0] recv_cnt;

    logic          issuing;
    logic          fill_hit;
    logic [15:0]   word_off;

    assign issuing  = (state == FILL) && (issue_cnt < ISSUE_END);
    // Returns outside FILL (idle, after the last word) are dropped here.
    assign fill_hit = (state == FILL) && mem_rvalid;
    assign word_off = 16'(issue_cnt[WW-1:0]) << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_i   <= 1'b0;
            base      <= 16'h0000;
            wdata     <= 16'h0000;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    if (d_wr) begin
                        state   <= WRITE;
                        owner_i <= 1'b0;
                        base    <= d_addr & 16'hFFFE;
                        wdata   <= d_wdata;
                    end else if (d_miss) begin
                        state   <= FILL;
                        owner_i <= 1'b0;
                        base    <= d_addr & LINE_MASK;
                    end else if (i_miss) begin
                        state   <= FILL;
                        owner_i <= 1'b1;
                        base    <= i_addr & LINE_MASK;
                    end
                end
                WRITE: begin
                    state <= DONE;
                end
                FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (mem_rvalid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (recv_cnt == LAST_WORD) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (state == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = base;
            mem_wdata = wdata;
        end else if (issuing) begin
            mem_en   = 1'b1;
            // OR, not add: word offsets never carry out of the line.
            mem_addr = base | word_off;
        end
    end

    assign i_fill_we = fill_hit & owner_i;
    assign d_fill_we = fill_hit & ~owner_i;
    assign fill_word = fill_hit ? recv_cnt : '0;
    assign fill_data = fill_hit ? mem_rdata : 16'h0000;
    assign i_done    = (state == DONE) & owner_i;
    assign d_done    = (state == DONE) & ~owner_i;
    assign busy      = (state != IDLE);

endmodule
